// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - sequential ALU: single-cycle ops plus iterative Booth multiply and signed restoring divide
module multicycle_alu #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [4:0]     opcode,
    input  logic [W-1:0]   y,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] z,
    output logic           div_zero
);

    localparam int SW = $clog2(W);
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W);

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_LOADI = 5'b00001;
    localparam logic [4:0] OP_STORE = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_AND   = 5'b00101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_SHR   = 5'b00111;
    localparam logic [4:0] OP_SHRA  = 5'b01000;
    localparam logic [4:0] OP_SHL   = 5'b01001;
    localparam logic [4:0] OP_ROR   = 5'b01010;
    localparam logic [4:0] OP_ROL   = 5'b01011;
    localparam logic [4:0] OP_ADDI  = 5'b01100;
    localparam logic [4:0] OP_ANDI  = 5'b01101;
    localparam logic [4:0] OP_ORI   = 5'b01110;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
    localparam logic [4:0] OP_NEG   = 5'b10001;
    localparam logic [4:0] OP_NOT   = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [4:0]    op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W:0]    acc;
    logic [W-1:0]  qr;
    logic          qm1;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = start && (state == S_IDLE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Divide by zero skips iteration and is resolved in EXEC like a single-cycle op.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        state_nx = S_MUL;
                    end else if (opcode == OP_DIV && b != '0) begin
                        state_nx = S_DIV;
                    end else begin
                        state_nx = S_EXEC;
                    end
                end
            end
            S_EXEC:       state_nx = S_IDLE;
            S_MUL, S_DIV: state_nx = (cnt == LAST) ? S_FIN : state;
            S_FIN:        state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
        endcase
    end

    // The cnt==0 cycle of MUL/DIV is the operand setup cycle and is not reported as busy.
    always_comb begin
        busy = ((state == S_MUL || state == S_DIV) && cnt != '0) || (state == S_FIN);
    end

    logic [SW-1:0]  sh;
    logic [SW:0]    sh_inv;
    logic [W-1:0]   alu_res;
    logic [2*W-1:0] exec_z;

    assign sh     = b_q[SW-1:0];
    assign sh_inv = (SW+1)'(W) - {1'b0, sh};

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_LOAD, OP_LOADI, OP_STORE, OP_ADD, OP_ADDI: alu_res = a_q + b_q;
            OP_SUB:          alu_res = a_q - b_q;
            OP_AND, OP_ANDI: alu_res = a_q & b_q;
            OP_OR, OP_ORI:   alu_res = a_q | b_q;
            OP_SHR:          alu_res = a_q >> sh;
            OP_SHRA:         alu_res = $signed(a_q) >>> sh;
            OP_SHL:          alu_res = a_q << sh;
            OP_ROR:          alu_res = (a_q >> sh) | (a_q << sh_inv);
            OP_ROL:          alu_res = (a_q << sh) | (a_q >> sh_inv);
            OP_NEG:          alu_res = -b_q;
            OP_NOT:          alu_res = ~b_q;
            default:         alu_res = '0;
        endcase
        exec_z = (op_q == OP_DIV) ? {a_q, {W{1'b1}}} : {{W{1'b0}}, alu_res};
    end

    logic [W:0] m_ext;
    logic [W:0] booth_sum;

    always_comb begin
        m_ext = {a_q[W-1], a_q};
        case ({qr[0], qm1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
    end

    logic [W-1:0] dvd_mag;
    logic [W-1:0] dvs_mag;
    logic [W:0]   div_shift;
    logic [W:0]   div_diff;
    logic         div_ge;
    logic [W-1:0] quot;
    logic [W-1:0] rem;

    // Magnitudes are unsigned W-bit, so |MIN| still fits and MIN/-1 wraps naturally in the fixup.
    always_comb begin
        dvd_mag   = a_q[W-1] ? -a_q : a_q;
        dvs_mag   = b_q[W-1] ? -b_q : b_q;
        div_shift = {acc[W-1:0], qr[W-1]};
        div_diff  = div_shift - {1'b0, dvs_mag};
        div_ge    = div_shift >= {1'b0, dvs_mag};
        quot      = (a_q[W-1] ^ b_q[W-1]) ? -qr : qr;
        rem       = a_q[W-1] ? -acc[W-1:0] : acc[W-1:0];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            qr       <= '0;
            qm1      <= 1'b0;
            cnt      <= '0;
            z        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= opcode;
                        a_q      <= y;
                        b_q      <= b;
                        cnt      <= '0;
                        div_zero <= 1'b0;
                    end
                end
                S_EXEC: begin
                    z        <= exec_z;
                    done     <= 1'b1;
                    div_zero <= (op_q == OP_DIV);
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        acc <= '0;
                        qr  <= b_q;
                        qm1 <= 1'b0;
                    end else begin
                        acc <= {booth_sum[W], booth_sum[W:1]};
                        qr  <= {booth_sum[0], qr[W-1:1]};
                        qm1 <= qr[0];
                    end
                    cnt <= cnt + CW'(1);
                end
                S_DIV: begin
                    if (cnt == '0) begin
                        acc <= '0;
                        qr  <= dvd_mag;
                    end else begin
                        acc <= div_ge ? div_diff : div_shift;
                        qr  <= {qr[W-2:0], div_ge};
                    end
                    cnt <= cnt + CW'(1);
                end
                S_FIN: begin
                    z    <= (op_q == OP_MUL) ? {acc[W-1:0], qr} : {rem, quot};
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu with a cycle-level reference model
module tb_multicycle_alu;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic           start = 1'b0;
    logic [4:0]     opcode = '0;
    logic [W-1:0]   y = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] z;
    logic           div_zero;

    multicycle_alu #(.W(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .opcode   (opcode),
        .y        (y),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .z        (z),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model: the op accepted at edge m_acc_edge completes at m_done_edge with m_z_new.
    logic [63:0] m_z_old = '0;
    logic [63:0] m_z_new = '0;
    logic        m_dz_old = 1'b0;
    logic        m_dz_new = 1'b0;
    int          m_done_edge = -1;
    int          m_acc_edge = -1;
    int          m_busy_lo = 1;
    int          m_busy_hi = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_z(input logic [4:0] op, input logic [31:0] a, input logic [31:0] bb);
        longint sa;
        longint sb;
        longint q;
        longint r;
        int     sh;
        logic [31:0] res;
        sa  = $signed(a);
        sb  = $signed(bb);
        sh  = int'(bb[4:0]);
        res = '0;
        case (op)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100: res = a + bb;
            5'b00100: res = a - bb;
            5'b00101, 5'b01101: res = a & bb;
            5'b00110, 5'b01110: res = a | bb;
            5'b00111: res = a >> sh;
            5'b01000: res = $signed(a) >>> sh;
            5'b01001: res = a << sh;
            5'b01010: res = (a >> sh) | (a << (32 - sh));
            5'b01011: res = (a << sh) | (a >> (32 - sh));
            5'b01111: return 64'(sa * sb);
            5'b10000: begin
                if (bb == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            5'b10001: res = -bb;
            5'b10010: res = ~bb;
            default:  res = '0;
        endcase
        return {32'h0, res};
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] bb);
        if (op == 5'b01111) return W + 2;
        if (op == 5'b10000 && bb != 0) return W + 2;
        return 1;
    endfunction

    task automatic model_accept(input logic [4:0] op, input logic [31:0] a, input logic [31:0] bb, input int n);
        int lat;
        lat        = ref_lat(op, bb);
        m_z_old    = m_z_new;
        m_dz_old   = m_dz_new;
        m_z_new    = ref_z(op, a, bb);
        m_dz_new   = (op == 5'b10000) && (bb == 0);
        m_acc_edge = n;
        m_done_edge = n + lat;
        m_busy_lo  = (lat > 1) ? n + 1 : 1;
        m_busy_hi  = (lat > 1) ? n + lat - 1 : 0;
    endtask

    task automatic model_reset();
        m_z_old     = '0;
        m_z_new     = '0;
        m_dz_old    = 1'b0;
        m_dz_new    = 1'b0;
        m_done_edge = -1;
        m_acc_edge  = -1;
        m_busy_lo   = 1;
        m_busy_hi   = 0;
    endtask

    always @(negedge clk) begin : cmp
        logic [63:0] ez;
        logic        ed;
        logic        eb;
        logic        edz;
        if (cyc >= 1) begin
            ez  = (cyc >= m_done_edge) ? m_z_new : m_z_old;
            ed  = (cyc == m_done_edge);
            eb  = (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
            edz = (cyc >= m_done_edge) ? m_dz_new : ((cyc >= m_acc_edge) ? 1'b0 : m_dz_old);
            check("cyc_done", done, ed);
            check("cyc_busy", busy, eb);
            check("cyc_z", z, ez);
            check("cyc_div_zero", div_zero, edz);
        end
    end

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] bb,
                          input bit imm, input bit mid, input logic [63:0] lit_z, input int lit_lat,
                          input logic lit_dz);
        int sedge;
        int lat;
        int bcnt;
        bit seen;
        if (!imm) @(negedge clk);
        #1;
        opcode = op;
        y      = a;
        b      = bb;
        start  = 1'b1;
        sedge  = cyc + 1;
        if (sedge > m_done_edge) model_accept(op, a, bb, sedge);
        @(negedge clk);
        #1;
        start  = 1'b0;
        opcode = ~op;
        y      = ~a;
        b      = bb ^ 32'h5A5A_A5A5;
        bcnt = 0;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk);
            if (mid && k == 10) begin
                start  = 1'b1;
                opcode = 5'b00011;
                y      = 32'h0000_1234;
                b      = 32'h0000_0001;
            end
            if (mid && k == 11) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = cyc - sedge;
            end else if (busy) begin
                bcnt++;
            end
        end
        check({name, " done_seen"}, seen, 1'b1);
        check({name, " latency"}, lat, lit_lat);
        check({name, " busy_cycles"}, bcnt, (lit_lat > 1) ? lit_lat - 1 : 0);
        check({name, " z"}, z, lit_z);
        check({name, " div_zero"}, div_zero, lit_dz);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        check("reset_z", z, 64'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_div_zero", div_zero, 1'b0);
        #1 clr = 1'b0;

        run_op("add_ovf", 5'b00011, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 64'h0000_0000_8000_0000, 1, 1'b0);
        run_op("shra",    5'b01000, 32'h8000_0000, 32'h0000_0004, 0, 0, 64'h0000_0000_F800_0000, 1, 1'b0);
        run_op("shr",     5'b00111, 32'h8000_0000, 32'h0000_0004, 0, 0, 64'h0000_0000_0800_0000, 1, 1'b0);
        run_op("ror",     5'b01010, 32'h0000_0001, 32'h0000_0001, 0, 0, 64'h0000_0000_8000_0000, 1, 1'b0);
        run_op("rol",     5'b01011, 32'h8000_0001, 32'h0000_0004, 0, 0, 64'h0000_0000_0000_0018, 1, 1'b0);
        run_op("shl",     5'b01001, 32'h0000_0003, 32'h0000_001F, 0, 0, 64'h0000_0000_8000_0000, 1, 1'b0);
        run_op("shl_amt", 5'b01001, 32'h0000_0001, 32'h0000_0021, 0, 0, 64'h0000_0000_0000_0002, 1, 1'b0);
        run_op("sub",     5'b00100, 32'h0000_0005, 32'h0000_0007, 0, 0, 64'h0000_0000_FFFF_FFFE, 1, 1'b0);
        run_op("andi",    5'b01101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 64'h0000_0000_00F0_00F0, 1, 1'b0);
        run_op("or",      5'b00110, 32'hF0F0_F0F0, 32'h0F0F_0000, 0, 0, 64'h0000_0000_FFFF_F0F0, 1, 1'b0);
        run_op("neg",     5'b10001, 32'h0000_007B, 32'h0000_0001, 0, 0, 64'h0000_0000_FFFF_FFFF, 1, 1'b0);
        run_op("not",     5'b10010, 32'h0000_0000, 32'h0000_FFFF, 0, 0, 64'h0000_0000_FFFF_0000, 1, 1'b0);
        run_op("undef",   5'b11111, 32'h1234_5678, 32'h0000_0001, 0, 0, 64'h0000_0000_0000_0000, 1, 1'b0);
        run_op("load",    5'b00000, 32'h0000_0002, 32'h0000_0003, 1, 0, 64'h0000_0000_0000_0005, 1, 1'b0);

        run_op("mul",     5'b01111, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0, 64'hFFFF_FFFF_FFFF_FFEB, 34, 1'b0);
        run_op("mul_mid", 5'b01111, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1, 64'hFFFF_FFFF_FFFF_FFEB, 34, 1'b0);
        run_op("mul_min", 5'b01111, 32'h8000_0000, 32'h8000_0000, 1, 0, 64'h4000_0000_0000_0000, 34, 1'b0);
        run_op("mul_m1",  5'b01111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'h0000_0000_0000_0001, 34, 1'b0);

        run_op("div",     5'b10000, 32'hFFFF_FFEF, 32'h0000_0005, 0, 0, 64'hFFFF_FFFE_FFFF_FFFD, 34, 1'b0);
        run_op("div_min", 5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 64'h0000_0000_8000_0000, 34, 1'b0);
        run_op("div_neg", 5'b10000, 32'h0000_0007, 32'hFFFF_FFFE, 1, 0, 64'h0000_0001_FFFF_FFFD, 34, 1'b0);
        run_op("div_zero", 5'b10000, 32'h0000_000A, 32'h0000_0000, 0, 0, 64'h0000_000A_FFFF_FFFF, 1, 1'b1);
        run_op("dz_clear", 5'b00011, 32'h0000_0001, 32'h0000_0001, 1, 0, 64'h0000_0000_0000_0002, 1, 1'b0);

        @(negedge clk);
        #1;
        opcode = 5'b01111;
        y      = 32'hFFFF_FFFD;
        b      = 32'h0000_0007;
        start  = 1'b1;
        model_accept(5'b01111, 32'hFFFF_FFFD, 32'h0000_0007, cyc + 1);
        @(negedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        clr = 1'b1;
        model_reset();
        @(negedge clk);
        check("clr_busy", busy, 1'b0);
        check("clr_z", z, 64'h0);
        check("clr_done", done, 1'b0);
        #1 clr = 1'b0;
        repeat (40) @(negedge clk);
        run_op("after_clr", 5'b00011, 32'h0000_0005, 32'h0000_0006, 0, 0, 64'h0000_0000_0000_000B, 1, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
